// File: rtl/rotary_pkg.sv
// Shared types and Gray-code tables for the rotary quadrature generator.
package rotary_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ZERO
  } state_t;

  localparam logic [1:0] QUAD_REST = 2'b00;

  // Index 0 is the first state after rest; index 3 is the rest state itself.
  localparam logic [1:0] CW_SEQ  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  localparam logic [1:0] CCW_SEQ [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  function automatic logic [1:0] gray_at(input logic dir, input logic [1:0] ph);
    return dir ? CW_SEQ[ph] : CCW_SEQ[ph];
  endfunction

endpackage

// File: rtl/quadrature_gen_phase_timer.sv
// Dwell down-counter: load starts a PHASE_CYCLES-long hold, expire marks its last cycle.
module phase_timer #(
  parameter int unsigned PHASE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);

  localparam int unsigned    DW     = $clog2(PHASE_CYCLES + 1);
  localparam logic [DW-1:0]  RELOAD = DW'(PHASE_CYCLES - 1);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - DW'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/quadrature_gen.sv
// Detented rotary-encoder emulator: emits CW/CCW Gray-code detents on quad_out per step command.
module quadrature_gen
  import rotary_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic [1:0]       quad_out,
  output logic             busy,
  output logic             step_done,
  output logic             cmd_done,
  output logic [7:0]       gen_pos
);

  state_t           state, state_nxt;
  logic [1:0]       phase;
  logic [CNT_W-1:0] remaining;
  logic             dir_q;
  logic             abort_q;
  logic [1:0]       quad_q;
  logic [7:0]       pos_q;
  logic             step_q;

  logic expire, timer_load, accept, phase_end, detent_end, last_detent;

  phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .expire (expire)
  );

  assign accept      = cmd_valid && (state == IDLE);
  assign phase_end   = (state == RUN) && expire;
  assign detent_end  = phase_end && (phase == 2'd3);
  assign last_detent = (remaining <= CNT_W'(1)) || abort_q;
  // Reload on every phase boundary except the one that ends the command.
  assign timer_load  = (accept && (cmd_count != '0)) ||
                       (phase_end && !(detent_end && last_detent));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (cmd_count == '0) ? ZERO : RUN;
      RUN:     if (detent_end && last_detent) state_nxt = IDLE;
      ZERO:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    cmd_done  = (state == ZERO) || (detent_end && last_detent);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= '0;
      remaining <= '0;
      dir_q     <= 1'b0;
      abort_q   <= 1'b0;
      quad_q    <= QUAD_REST;
      pos_q     <= '0;
      step_q    <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (accept) begin
        dir_q     <= cmd_dir;
        remaining <= cmd_count;
        abort_q   <= 1'b0;
        phase     <= '0;
        if (cmd_count != '0) quad_q <= gray_at(cmd_dir, 2'd0);
      end else if (busy && abort) begin
        abort_q <= 1'b1;
      end
      if (phase_end) begin
        if (phase == 2'd3) begin
          remaining <= remaining - CNT_W'(1);
          if (!last_detent) begin
            phase  <= '0;
            quad_q <= gray_at(dir_q, 2'd0);
          end
        end else begin
          phase  <= phase + 2'd1;
          quad_q <= gray_at(dir_q, phase + 2'd1);
          // Entering rest completes the detent; position tracks the decoder's count.
          if (phase == 2'd2) begin
            step_q <= 1'b1;
            pos_q  <= dir_q ? pos_q + 8'd1 : pos_q - 8'd1;
          end
        end
      end
    end
  end

  assign quad_out  = quad_q;
  assign step_done = step_q;
  assign gen_pos   = pos_q;

endmodule

// File: tb/tb_quadrature_gen.sv
// Directed self-checking bench for quadrature_gen with PHASE_CYCLES=4.
module tb_quadrature_gen;

  localparam int unsigned P = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_count = '0;
  logic       abort = 1'b0;
  logic [1:0] quad_out;
  logic       busy;
  logic       step_done;
  logic       cmd_done;
  logic [7:0] gen_pos;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [1:0] cw_tab  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] ccw_tab [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  always #5 clk = ~clk;

  quadrature_gen #(.PHASE_CYCLES(P), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_count (cmd_count),
    .abort     (abort),
    .quad_out  (quad_out),
    .busy      (busy),
    .step_done (step_done),
    .cmd_done  (cmd_done),
    .gen_pos   (gen_pos)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Offer a command in the current cycle, then check each following cycle.
  // n_exp detents are expected; abort pulses at cycle abort_t (0 = never);
  // stop_t > 0 leaves the loop early without end-of-command checks.
  task automatic run_cmd(input logic dir, input logic [7:0] n, input int unsigned abort_t,
                         input int unsigned n_exp, input int unsigned stop_t);
    int unsigned last;
    int unsigned ph;
    check("ready_before", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_count = n;
    next_cycle();
    cmd_valid = 1'b0;
    cmd_count = 8'd0;
    last = (stop_t > 0) ? stop_t : 4 * n_exp * P;
    for (int unsigned t = 1; t <= last; t++) begin
      abort = (t == abort_t);
      ph = ((t - 1) / P) % 4;
      check($sformatf("quad t=%0d", t), quad_out, dir ? cw_tab[ph] : ccw_tab[ph]);
      check($sformatf("busy t=%0d", t), busy, 1);
      check($sformatf("ready t=%0d", t), cmd_ready, 0);
      check($sformatf("step t=%0d", t), step_done, ((t - 1) % (4 * P)) == 3 * P);
      check($sformatf("done t=%0d", t), cmd_done, (stop_t == 0) && (t == 4 * n_exp * P));
      next_cycle();
    end
    abort = 1'b0;
    if (stop_t == 0) begin
      check("ready_after", cmd_ready, 1);
      check("busy_after", busy, 0);
      check("done_after", cmd_done, 0);
      check("quad_after", quad_out, 2'b00);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_quad", quad_out, 2'b00);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_step", step_done, 0);
    check("rst_done", cmd_done, 0);
    check("rst_pos", gen_pos, 0);
    rst_n = 1'b1;
    next_cycle();

    // CW single detent
    run_cmd(1'b1, 8'd1, 0, 1, 0);
    check("cw1_pos", gen_pos, 8'd1);

    // abort while idle is ignored: both detents of the next command run
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    run_cmd(1'b1, 8'd2, 0, 2, 0);
    check("cw2_pos", gen_pos, 8'd3);

    // CCW three detents from zero wraps to 253
    do_reset();
    check("ccw_start_pos", gen_pos, 8'd0);
    run_cmd(1'b0, 8'd3, 0, 3, 0);
    check("ccw3_pos", gen_pos, 8'd253);

    // zero-count command
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_count = 8'd0;
    next_cycle();
    cmd_valid = 1'b0;
    check("n0_busy", busy, 1);
    check("n0_done", cmd_done, 1);
    check("n0_ready", cmd_ready, 0);
    check("n0_quad", quad_out, 2'b00);
    next_cycle();
    check("n0_ready_after", cmd_ready, 1);
    check("n0_done_after", cmd_done, 0);
    check("n0_busy_after", busy, 0);
    check("n0_pos", gen_pos, 8'd253);

    // abort mid-detent 2 of a 10-detent command
    do_reset();
    run_cmd(1'b1, 8'd10, 4 * P + 5, 2, 0);
    check("abort_pos", gen_pos, 8'd2);
    repeat (2 * P) begin
      check("abort_quiet_step", step_done, 0);
      next_cycle();
    end

    // async reset during phase 11 of detent 2
    do_reset();
    run_cmd(1'b1, 8'd3, 0, 3, 4 * P + P + 2);
    check("pre_rst_quad", quad_out, 2'b11);
    check("pre_rst_pos", gen_pos, 8'd1);
    rst_n = 1'b0;
    #1;
    check("async_quad", quad_out, 2'b00);
    check("async_busy", busy, 0);
    check("async_pos", gen_pos, 8'd0);
    check("async_ready", cmd_ready, 1);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    run_cmd(1'b0, 8'd1, 0, 1, 0);
    check("post_rst_pos", gen_pos, 8'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
